// File: rtl/matrix_pkg.sv
// Shared types and defaults for the matrix operand loader and its index counter.
package matrix_pkg;
  localparam int DATA_W_DEF  = 32;
  localparam int DIM_MAX_DEF = 8;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LOAD_A,
    ST_LOAD_B,
    ST_KICK,
    ST_WAIT_ACK,
    ST_WAIT_DONE
  } loader_state_t;

  localparam logic SEL_A = 1'b0;
  localparam logic SEL_B = 1'b1;
endpackage

// File: rtl/matrix_index_counter.sv
// Row-major (row,col) walker. Load sets bounds and clears indices; step advances one element;
// last flags the final element of the current bounds.
module matrix_index_counter #(
  parameter int IDX_W = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             load,
  input  logic [IDX_W-1:0] load_rows,
  input  logic [IDX_W-1:0] load_cols,
  input  logic             step,
  output logic [IDX_W-1:0] row,
  output logic [IDX_W-1:0] col,
  output logic             last
);
  localparam logic [IDX_W-1:0] ONE = IDX_W'(1);

  logic [IDX_W-1:0] rows_q;
  logic [IDX_W-1:0] cols_q;
  logic             col_last;

  assign col_last = (col == cols_q - ONE);
  assign last     = col_last && (row == rows_q - ONE);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rows_q <= '0;
      cols_q <= '0;
      row    <= '0;
      col    <= '0;
    end else if (load) begin
      rows_q <= load_rows;
      cols_q <= load_cols;
      row    <= '0;
      col    <= '0;
    end else if (step) begin
      // Wrap row too on the final element so indices never exceed dims-1.
      if (col_last) begin
        col <= '0;
        row <= last ? '0 : row + ONE;
      end else begin
        col <= col + ONE;
      end
    end
  end
endmodule

// File: rtl/matrix_operand_loader.sv
// Streams A (MxK) then B (KxN) row-major words into the multiplier operand store, then kicks it.
// Optional MATRIX_LOADER_DIMCHECK_EN adds cfg_err and rejects out-of-range dimensions.
module matrix_operand_loader
  import matrix_pkg::*;
#(
  parameter int DATA_W  = DATA_W_DEF,
  parameter int DIM_MAX = DIM_MAX_DEF,
  parameter int IDX_W   = $clog2(DIM_MAX + 1)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              cfg_valid,
  output logic              cfg_ready,
  input  logic [IDX_W-1:0]  cfg_rows_a,
  input  logic [IDX_W-1:0]  cfg_cols_a,
  input  logic [IDX_W-1:0]  cfg_cols_b,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  output logic              wr_en,
  output logic              wr_sel,
  output logic [IDX_W-1:0]  wr_row,
  output logic [IDX_W-1:0]  wr_col,
  output logic [DATA_W-1:0] wr_data,
  output logic              mul_start,
  input  logic              mul_done,
  output logic              busy
`ifdef MATRIX_LOADER_DIMCHECK_EN
  ,
  output logic              cfg_err
`endif
);
  loader_state_t    state, state_nxt;
  logic             cfg_hs, in_hs, dims_ok, cfg_accept;
  logic [IDX_W-1:0] dim_k, dim_n;
  logic             idx_load, idx_last;
  logic [IDX_W-1:0] idx_rows, idx_cols, idx_row, idx_col;

  assign cfg_hs = cfg_valid && cfg_ready;
  assign in_hs  = in_valid && in_ready;

`ifdef MATRIX_LOADER_DIMCHECK_EN
  assign dims_ok = (cfg_rows_a != '0) && (cfg_rows_a <= IDX_W'(DIM_MAX)) &&
                   (cfg_cols_a != '0) && (cfg_cols_a <= IDX_W'(DIM_MAX)) &&
                   (cfg_cols_b != '0) && (cfg_cols_b <= IDX_W'(DIM_MAX));
`else
  assign dims_ok = 1'b1;
`endif
  assign cfg_accept = cfg_hs && dims_ok;

  // One counter serves both operands: loaded with MxK on config, reloaded with KxN after A.
  assign idx_load = cfg_accept || ((state == ST_LOAD_A) && in_hs && idx_last);
  assign idx_rows = (state == ST_IDLE) ? cfg_rows_a : dim_k;
  assign idx_cols = (state == ST_IDLE) ? cfg_cols_a : dim_n;

  matrix_index_counter #(.IDX_W(IDX_W)) u_idx (
    .clk       (clk),
    .reset     (reset),
    .load      (idx_load),
    .load_rows (idx_rows),
    .load_cols (idx_cols),
    .step      (in_hs),
    .row       (idx_row),
    .col       (idx_col),
    .last      (idx_last)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= ST_IDLE;
      dim_k <= '0;
      dim_n <= '0;
    end else begin
      state <= state_nxt;
      if (cfg_accept) begin
        dim_k <= cfg_cols_a;
        dim_n <= cfg_cols_b;
      end
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE:      if (cfg_accept)         state_nxt = ST_LOAD_A;
      ST_LOAD_A:    if (in_hs && idx_last)  state_nxt = ST_LOAD_B;
      ST_LOAD_B:    if (in_hs && idx_last)  state_nxt = ST_KICK;
      ST_KICK:                              state_nxt = ST_WAIT_ACK;
      // Done idles high, so it must be seen low before a rise counts as completion.
      ST_WAIT_ACK:  if (!mul_done)          state_nxt = ST_WAIT_DONE;
      ST_WAIT_DONE: if (mul_done)           state_nxt = ST_IDLE;
      default:                              state_nxt = ST_IDLE;
    endcase
  end

  always_comb begin
    cfg_ready = (state == ST_IDLE);
    in_ready  = (state == ST_LOAD_A) || (state == ST_LOAD_B);
    busy      = (state != ST_IDLE);
  end

  // Write port and start pulse: registered one cycle behind the handshake / KICK state.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_en     <= 1'b0;
      wr_sel    <= SEL_A;
      wr_row    <= '0;
      wr_col    <= '0;
      wr_data   <= '0;
      mul_start <= 1'b0;
    end else begin
      wr_en     <= in_hs;
      mul_start <= (state == ST_KICK);
      if (in_hs) begin
        wr_sel  <= (state == ST_LOAD_B) ? SEL_B : SEL_A;
        wr_row  <= idx_row;
        wr_col  <= idx_col;
        wr_data <= in_data;
      end
    end
  end

`ifdef MATRIX_LOADER_DIMCHECK_EN
  always_ff @(posedge clk or posedge reset) begin
    if (reset) cfg_err <= 1'b0;
    else       cfg_err <= cfg_hs && !dims_ok;
  end
`endif
endmodule

// File: tb/tb_matrix_operand_loader.sv
// Directed bench for matrix_operand_loader; covers the dimension check when
// MATRIX_LOADER_DIMCHECK_EN is defined.
module tb_matrix_operand_loader;
  localparam int DATA_W  = 32;
  localparam int DIM_MAX = 8;
  localparam int IDX_W   = 4;

  logic              clk = 1'b0;
  logic              reset;
  logic              cfg_valid;
  logic              cfg_ready;
  logic [IDX_W-1:0]  cfg_rows_a, cfg_cols_a, cfg_cols_b;
  logic              in_valid;
  logic              in_ready;
  logic [DATA_W-1:0] in_data;
  logic              wr_en, wr_sel;
  logic [IDX_W-1:0]  wr_row, wr_col;
  logic [DATA_W-1:0] wr_data;
  logic              mul_start;
  logic              mul_done;
  logic              busy;
`ifdef MATRIX_LOADER_DIMCHECK_EN
  logic              cfg_err;
`endif

  matrix_operand_loader #(.DATA_W(DATA_W), .DIM_MAX(DIM_MAX), .IDX_W(IDX_W)) dut (
    .clk        (clk),
    .reset      (reset),
    .cfg_valid  (cfg_valid),
    .cfg_ready  (cfg_ready),
    .cfg_rows_a (cfg_rows_a),
    .cfg_cols_a (cfg_cols_a),
    .cfg_cols_b (cfg_cols_b),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_data    (in_data),
    .wr_en      (wr_en),
    .wr_sel     (wr_sel),
    .wr_row     (wr_row),
    .wr_col     (wr_col),
    .wr_data    (wr_data),
    .mul_start  (mul_start),
    .mul_done   (mul_done),
    .busy       (busy)
`ifdef MATRIX_LOADER_DIMCHECK_EN
    ,
    .cfg_err    (cfg_err)
`endif
  );

  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;

  task automatic check_val(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Write/start monitor
  int          cyc = 0;
  logic [63:0] wq[$];
  int          wcyc[$];
  int          scyc[$];

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (wr_en) begin
      wq.push_back({23'd0, wr_sel, wr_row, wr_col, wr_data});
      wcyc.push_back(cyc);
    end
    if (mul_start) scyc.push_back(cyc);
  end

  function automatic logic [63:0] wexp(input logic sel, input int r, input int c, input int d);
    return {23'd0, sel, r[3:0], c[3:0], d[31:0]};
  endfunction

  task automatic clear_mon();
    wq.delete();
    wcyc.delete();
    scyc.delete();
  endtask

  task automatic send_cfg(input int m, input int k, input int n);
    int t;
    t = 0;
    cfg_valid  = 1'b1;
    cfg_rows_a = IDX_W'(m);
    cfg_cols_a = IDX_W'(k);
    cfg_cols_b = IDX_W'(n);
    while (!cfg_ready && t < 50) begin
      @(posedge clk); #1;
      t++;
    end
    if (!cfg_ready) check_val("cfg_timeout", 64'd0, 64'd1);
    @(posedge clk); #1;
    cfg_valid = 1'b0;
  endtask

  task automatic send_words(input int n, input int base, input bit toggle);
    int t;
    for (int i = 0; i < n; i++) begin
      t = 0;
      in_valid = 1'b1;
      in_data  = DATA_W'(base + i);
      while (!in_ready && t < 50) begin
        @(posedge clk); #1;
        t++;
      end
      if (!in_ready) begin
        check_val("in_timeout", 64'd0, 64'd1);
        break;
      end
      @(posedge clk); #1;
      if (toggle) begin
        in_valid = 1'b0;
        @(posedge clk); #1;
      end
    end
    in_valid = 1'b0;
  endtask

  task automatic wait_start();
    int t;
    t = 0;
    while (scyc.size() == 0 && t < 100) begin
      @(posedge clk); #1;
      t++;
    end
    if (scyc.size() == 0) check_val("start_timeout", 64'd0, 64'd1);
  endtask

  task automatic finish_job();
    wait_start();
    mul_done = 1'b0;
    @(posedge clk); #1;
    mul_done = 1'b1;
    @(posedge clk); #1;
    check_val("idle_after_done", busy, 64'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b1; cfg_valid = 1'b0; cfg_rows_a = '0; cfg_cols_a = '0; cfg_cols_b = '0;
    in_valid = 1'b0; in_data = '0; mul_done = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    check_val("rst_cfg_ready", cfg_ready, 64'd1);
    check_val("rst_busy", busy, 64'd0);
    check_val("rst_in_ready", in_ready, 64'd0);
    reset = 1'b0;
    @(posedge clk); #1;

    // 1: reset mid LOAD_A with word 3 pending
    send_cfg(2, 3, 2);
    send_words(3, 1, 1'b0);
    in_valid = 1'b1;
    in_data  = 32'd4;
    reset    = 1'b1;
    #1;
    check_val("r1_cfg_ready", cfg_ready, 64'd1);
    check_val("r1_busy", busy, 64'd0);
    check_val("r1_in_ready", in_ready, 64'd0);
    check_val("r1_wr_bus", {wr_en, wr_sel, wr_row, wr_col, wr_data}, 64'd0);
    check_val("r1_mul_start", mul_start, 64'd0);
    in_valid = 1'b0;
    @(posedge clk); #1;
    reset = 1'b0;
    @(posedge clk); #1;
    clear_mon();

    // 2: 2x3 * 3x2, back-to-back words 1..12
    send_cfg(2, 3, 2);
    send_words(12, 1, 1'b0);
    finish_job();
    check_val("t2_wr_count", wq.size(), 64'd12);
    for (int i = 0; i < 12 && i < wq.size(); i++) begin
      if (i < 6) check_val($sformatf("t2_A%0d", i), wq[i], wexp(1'b0, i / 3, i % 3, i + 1));
      else       check_val($sformatf("t2_B%0d", i), wq[i], wexp(1'b1, (i - 6) / 2, (i - 6) % 2, i + 1));
    end
    check_val("t2_start_count", scyc.size(), 64'd1);
    if (wcyc.size() == 12 && scyc.size() == 1) begin
      check_val("t2_back_to_back", wcyc[11] - wcyc[0], 64'd11);
      check_val("t2_start_after_last", scyc[0] - wcyc[11], 64'd1);
    end
    clear_mon();

    // 3: 1x1 * 1x1 with in_valid toggling
    send_cfg(1, 1, 1);
    send_words(2, 100, 1'b1);
    finish_job();
    check_val("t3_wr_count", wq.size(), 64'd2);
    if (wq.size() == 2) begin
      check_val("t3_A00", wq[0], wexp(1'b0, 0, 0, 100));
      check_val("t3_B00", wq[1], wexp(1'b1, 0, 0, 101));
    end
    check_val("t3_start_count", scyc.size(), 64'd1);
    clear_mon();

    // 4: done handshake timing
    send_cfg(1, 1, 1);
    send_words(2, 200, 1'b0);
    wait_start();
    repeat (3) begin
      @(posedge clk); #1;
      check_val("t4_busy_done_hi", busy, 64'd1);
    end
    mul_done = 1'b0;
    repeat (10) begin
      @(posedge clk); #1;
      check_val("t4_busy_done_lo", busy, 64'd1);
    end
    mul_done = 1'b1;
    @(negedge clk);
    check_val("t4_busy_at_rise", busy, 64'd1);
    check_val("t4_cfg_ready_at_rise", cfg_ready, 64'd0);
    @(posedge clk); #1;
    check_val("t4_cfg_ready_after", cfg_ready, 64'd1);
    check_val("t4_busy_after", busy, 64'd0);
    clear_mon();

    // 5: cfg_valid and in_valid together in IDLE
    cfg_valid = 1'b1; cfg_rows_a = 4'd1; cfg_cols_a = 4'd1; cfg_cols_b = 4'd1;
    in_valid  = 1'b1; in_data = 32'h55;
    @(negedge clk);
    check_val("t5_in_ready_idle", in_ready, 64'd0);
    @(posedge clk); #1;
    cfg_valid = 1'b0;
    check_val("t5_no_wr_idle", wr_en, 64'd0);
    check_val("t5_busy", busy, 64'd1);
    @(posedge clk); #1;
    check_val("t5_wr_in_load", wr_en, 64'd1);
    send_words(1, 'h66, 1'b0);
    finish_job();
    check_val("t5_wr_count", wq.size(), 64'd2);
    if (wq.size() == 2) begin
      check_val("t5_A00", wq[0], wexp(1'b0, 0, 0, 'h55));
      check_val("t5_B00", wq[1], wexp(1'b1, 0, 0, 'h66));
    end
    clear_mon();

`ifdef MATRIX_LOADER_DIMCHECK_EN
    // 6: zero dimension rejected, then 8x8x8 accepted
    check_val("t6_err_idle", cfg_err, 64'd0);
    cfg_valid = 1'b1; cfg_rows_a = 4'd0; cfg_cols_a = 4'd2; cfg_cols_b = 4'd2;
    @(posedge clk); #1;
    cfg_valid = 1'b0;
    check_val("t6_err_pulse", cfg_err, 64'd1);
    check_val("t6_busy_rej", busy, 64'd0);
    @(posedge clk); #1;
    check_val("t6_err_clear", cfg_err, 64'd0);
    check_val("t6_busy_idle", busy, 64'd0);
    send_cfg(8, 8, 8);
    check_val("t6_err_ok", cfg_err, 64'd0);
    check_val("t6_busy_ok", busy, 64'd1);
    check_val("t6_in_ready_ok", in_ready, 64'd1);
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
